// File: rtl/glyph_table_loader.sv
// Byte-stream loader for the glyph table: parses marker/code/64-word/checksum
// frames and issues one-cycle write strobes into the glyph RAM.
module glyph_table_loader #(
    parameter int TIMEOUT = 50000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        wea,
    output logic [12:0] addra,
    output logic [15:0] dina,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);
    localparam logic [7:0]  MARKER      = 8'h47;

    typedef enum logic [2:0] {
        IDLE,
        CODE,
        DATA_HI,
        DATA_LO,
        CHECK
    } stateType;

    stateType    state;
    logic [6:0]  code;
    logic [5:0]  wordIdx;
    logic [7:0]  hiByte;
    logic [7:0]  csum;
    logic [15:0] idleCnt;
    logic        accept;
    logic        timeoutHit;

    assign accept     = rx_valid & rx_ready;
    assign busy       = (state != IDLE);
    // Fires on the cycle the counter would reach TIMEOUT; an accepted byte wins.
    assign timeoutHit = busy && !accept && ((idleCnt + 16'd1) == TIMEOUT_CNT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            rx_ready <= 1'b0;
            wea      <= 1'b0;
            addra    <= '0;
            dina     <= '0;
            done     <= 1'b0;
            error    <= 1'b0;
            code     <= '0;
            wordIdx  <= '0;
            hiByte   <= '0;
            csum     <= '0;
            idleCnt  <= '0;
        end else begin
            rx_ready <= 1'b1;
            wea      <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;

            if (accept || !busy || timeoutHit) begin
                idleCnt <= '0;
            end else begin
                idleCnt <= idleCnt + 16'd1;
            end

            if (accept) begin
                case (state)
                    IDLE: begin
                        if (rx_data == MARKER) begin
                            state <= CODE;
                        end
                    end
                    CODE: begin
                        if (rx_data[7]) begin
                            error <= 1'b1;
                            state <= IDLE;
                        end else begin
                            code    <= rx_data[6:0];
                            wordIdx <= '0;
                            csum    <= rx_data;
                            state   <= DATA_HI;
                        end
                    end
                    DATA_HI: begin
                        hiByte <= rx_data;
                        csum   <= csum ^ rx_data;
                        state  <= DATA_LO;
                    end
                    DATA_LO: begin
                        wea     <= 1'b1;
                        addra   <= {code, wordIdx};
                        dina    <= {hiByte, rx_data};
                        csum    <= csum ^ rx_data;
                        wordIdx <= wordIdx + 6'd1;
                        state   <= (wordIdx == 6'd63) ? CHECK : DATA_HI;
                    end
                    CHECK: begin
                        if (rx_data == csum) begin
                            done <= 1'b1;
                        end else begin
                            error <= 1'b1;
                        end
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end else if (timeoutHit) begin
                error <= 1'b1;
                state <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_glyph_table_loader.sv
// Bench for glyph_table_loader: frame vector table, hand-written corner
// sequences and a random byte stream checked against a frame-parsing model.
module tb_glyph_table_loader;

    logic        clk;
    logic        reset_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        wea;
    logic [12:0] addra;
    logic [15:0] dina;
    logic        busy;
    logic        done;
    logic        error;

    int total = 0;
    int bad   = 0;

    logic [28:0] obsW[$];
    int          obsEv[$];
    logic [28:0] expW[$];
    int          expEv[$];
    logic [7:0]  stream[$];

    typedef struct {
        logic [7:0]  code;
        logic [15:0] base;
        logic [15:0] step;
        logic [7:0]  flip;
        int          nWrites;
        int          nDone;
        int          nErr;
        logic [12:0] addr0;
    } vecT;

    vecT vecs[5];

    glyph_table_loader #(.TIMEOUT(8)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .wea      (wea),
        .addra    (addra),
        .dina     (dina),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (wea) obsW.push_back({addra, dina});
        if (done) obsEv.push_back(1);
        if (error) obsEv.push_back(2);
        if (done || error) chk("doneErrExcl", 32'(done & error), 0);
    end

    // Called at posedge+1; the byte is taken on the next rising edge.
    task automatic sendByte(input logic [7:0] b, input int gap);
        int n = 0;
        while (rx_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (n == 20) begin
            total++; bad++;
            $display("FAIL rxReadyWait: got 0 want 1");
        end
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    task automatic sendFrame(input logic [7:0] code, input logic [15:0] base,
                             input logic [15:0] step, input logic [7:0] flip, input int gapMax);
        logic [7:0]  sum;
        logic [15:0] d;
        sendByte(8'h47, $urandom_range(0, gapMax));
        chk("busyAfterMarker", 32'(busy), 1);
        sendByte(code, $urandom_range(0, gapMax));
        if (!code[7]) begin
            sum = code;
            for (int w = 0; w < 64; w++) begin
                d = base + 16'(w) * step;
                sendByte(d[15:8], $urandom_range(0, gapMax));
                sendByte(d[7:0], $urandom_range(0, gapMax));
                sum = sum ^ d[15:8] ^ d[7:0];
            end
            sendByte(sum ^ flip, 0);
        end
    endtask

    task automatic runVector(input vecT v, input string tag);
        int nD, nE;
        logic [28:0] ew;
        obsW.delete(); obsEv.delete();
        sendFrame(v.code, v.base, v.step, v.flip, 2);
        repeat (3) begin @(posedge clk); #1; end
        nD = 0; nE = 0;
        foreach (obsEv[k]) begin
            if (obsEv[k] == 1) nD++;
            else nE++;
        end
        chk({tag, ".writes"}, obsW.size(), v.nWrites);
        chk({tag, ".done"}, nD, v.nDone);
        chk({tag, ".error"}, nE, v.nErr);
        chk({tag, ".busyEnd"}, 32'(busy), 0);
        for (int i = 0; i < obsW.size() && i < v.nWrites; i++) begin
            ew = {v.addr0 + 13'(i), v.base + 16'(i) * v.step};
            chk({tag, ".word"}, 32'(obsW[i]), 32'(ew));
        end
    endtask

    // Reference: walk the byte stream as whole frames by index arithmetic.
    task automatic modelParse();
        int i = 0;
        int n = stream.size();
        logic [7:0] c, hi, lo, sum;
        expW.delete(); expEv.delete();
        while (i < n) begin
            if (stream[i] != 8'h47) begin i++; continue; end
            if (i + 1 >= n) break;
            c = stream[i + 1];
            if (c[7]) begin expEv.push_back(2); i += 2; continue; end
            if (i + 130 >= n) break;
            sum = c;
            for (int w = 0; w < 64; w++) begin
                hi = stream[i + 2 + 2 * w];
                lo = stream[i + 3 + 2 * w];
                expW.push_back({c[6:0], 6'(w), hi, lo});
                sum = sum ^ hi ^ lo;
            end
            expEv.push_back((stream[i + 130] == sum) ? 1 : 2);
            i += 131;
        end
    endtask

    initial begin
        int errAt;
        logic [7:0] c, sum, b;

        vecs[0] = '{8'h41, 16'h0000, 16'h0001, 8'h00, 64, 1, 0, 13'h1040};
        vecs[1] = '{8'h41, 16'h0000, 16'h0001, 8'h01, 64, 0, 1, 13'h1040};
        vecs[2] = '{8'h80, 16'h0000, 16'h0000, 8'h00, 0, 0, 1, 13'h0000};
        vecs[3] = '{8'h00, 16'hA55A, 16'h0101, 8'h00, 64, 1, 0, 13'h0000};
        vecs[4] = '{8'h7F, 16'h4747, 16'h1111, 8'h00, 64, 1, 0, 13'h1FC0};

        reset_n  = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.rx_ready", 32'(rx_ready), 0);
        chk("rst.wea", 32'(wea), 0);
        chk("rst.addra", 32'(addra), 0);
        chk("rst.dina", 32'(dina), 0);
        chk("rst.busy", 32'(busy), 0);
        chk("rst.done", 32'(done), 0);
        chk("rst.error", 32'(error), 0);
        reset_n = 1'b1;
        #1 chk("rst.readyLow", 32'(rx_ready), 0);
        @(posedge clk); #1;
        chk("rst.readyRise", 32'(rx_ready), 1);

        for (int i = 0; i < 5; i++) runVector(vecs[i], $sformatf("vec%0d", i));

        // Noise in IDLE, then a normal frame.
        obsW.delete(); obsEv.delete();
        sendByte(8'h00, 0); chk("noise.busy0", 32'(busy), 0);
        sendByte(8'hFF, 0); chk("noise.busy1", 32'(busy), 0);
        sendByte(8'h41, 1); chk("noise.busy2", 32'(busy), 0);
        chk("noise.writes", obsW.size(), 0);
        chk("noise.events", obsEv.size(), 0);
        runVector(vecs[0], "afterNoise");

        // Stall after a 10-byte prefix.
        obsW.delete(); obsEv.delete();
        sendByte(8'h47, 0); sendByte(8'h05, 0);
        for (int k = 0; k < 8; k++) sendByte(8'(k + 1), 0);
        errAt = 0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (error && errAt == 0) errAt = k;
        end
        chk("to.latency", errAt, 8);
        chk("to.busy", 32'(busy), 0);
        chk("to.writes", obsW.size(), 4);
        chk("to.events", obsEv.size(), 1);

        // Byte lands on the edge the counter would reach TIMEOUT.
        obsW.delete(); obsEv.delete();
        sendByte(8'h47, 0); sendByte(8'h05, 0);
        repeat (7) begin @(posedge clk); #1; end
        sendByte(8'h12, 0);
        chk("edge.noError", 32'(error), 0);
        chk("edge.busy", 32'(busy), 1);
        chk("edge.events", obsEv.size(), 0);
        repeat (10) begin @(posedge clk); #1; end
        chk("edge.laterTimeout", obsEv.size(), 1);

        // Reset part-way through word 20.
        obsW.delete(); obsEv.delete();
        sendByte(8'h47, 0); sendByte(8'h22, 0);
        for (int k = 0; k < 41; k++) sendByte(8'(k), 0);
        #2 reset_n = 1'b0;
        #1;
        chk("mid.wea", 32'(wea), 0);
        chk("mid.addra", 32'(addra), 0);
        chk("mid.dina", 32'(dina), 0);
        chk("mid.busy", 32'(busy), 0);
        chk("mid.ready", 32'(rx_ready), 0);
        repeat (2) @(posedge clk);
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        repeat (3) begin @(posedge clk); #1; end
        chk("mid.noEvents", obsEv.size(), 0);
        runVector(vecs[0], "afterReset");

        // Random stream of noise and frames.
        stream.delete();
        for (int f = 0; f < 8; f++) begin
            repeat ($urandom_range(0, 3)) begin
                b = 8'($urandom_range(0, 255));
                stream.push_back((b == 8'h47) ? 8'h46 : b);
            end
            stream.push_back(8'h47);
            c = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 5) != 0) c[7] = 1'b0;
            stream.push_back(c);
            if (!c[7]) begin
                sum = c;
                for (int k = 0; k < 128; k++) begin
                    b = 8'($urandom_range(0, 255));
                    stream.push_back(b);
                    sum = sum ^ b;
                end
                stream.push_back(($urandom_range(0, 2) == 0) ? ~sum : sum);
            end
        end
        modelParse();
        obsW.delete(); obsEv.delete();
        foreach (stream[k]) sendByte(stream[k], $urandom_range(0, 4));
        repeat (4) begin @(posedge clk); #1; end
        chk("rand.writes", obsW.size(), expW.size());
        chk("rand.events", obsEv.size(), expEv.size());
        for (int i = 0; i < obsW.size() && i < expW.size(); i++)
            chk("rand.word", 32'(obsW[i]), 32'(expW[i]));
        for (int i = 0; i < obsEv.size() && i < expEv.size(); i++)
            chk("rand.event", obsEv[i], expEv[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/glyph_table_loader.md
GLYPH_TABLE_LOADER -- requirements
Module: glyph_table_loader

Interface
REQ-001 SHALL have parameter TIMEOUT, default 50000, giving the maximum idle clocks allowed between bytes inside a frame (range 2..65535).
REQ-002 SHALL have port clk  input  1  the single clock; all logic is on the rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port rx_data  input  8  incoming byte.
REQ-005 SHALL have port rx_valid  input  1  rx_data is valid this cycle.
REQ-006 SHALL have port rx_ready  output  1  loader can accept a byte.
REQ-007 SHALL have port wea  output  1  glyph-table write strobe, one cycle per word.
REQ-008 SHALL have port addra  output  13  glyph-table write address.
REQ-009 SHALL have port dina  output  16  glyph-table write data.
REQ-010 SHALL have port busy  output  1  a frame is in progress.
REQ-011 SHALL have port done  output  1  one-cycle pulse: frame accepted, checksum good.
REQ-012 SHALL have port error  output  1  one-cycle pulse: frame aborted or checksum bad.

Function
REQ-013 Byte transfer SHALL occur only when rx_valid=1 and rx_ready=1 are sampled together; rx_ready SHALL be 1 in every state after reset.
REQ-014 Frame format SHALL be: 0x47 marker, code byte, 128 data bytes (64 words, high byte first), checksum byte.
REQ-015 The checksum SHALL be the XOR of the code byte and all 128 data bytes.
REQ-016 States SHALL be IDLE, CODE, DATA_HI, DATA_LO and CHECK.
REQ-017 In IDLE: byte 0x47 -> CODE; any other byte is discarded and IDLE is kept.
REQ-018 In CODE with bit7=0: latch code[6:0], clear the word counter and the checksum, fold the byte into the checksum, go to DATA_HI.
REQ-019 In CODE with bit7=1: pulse error, return to IDLE, issue no writes.
REQ-020 In DATA_HI: latch the high byte, go to DATA_LO.
REQ-021 In DATA_LO: form a word from the latched high byte and the received low byte, then go to DATA_HI, or to CHECK if this was word 63.
REQ-022 Word address SHALL be {code[6:0], word_idx[5:0]}; word_idx[5:3] is the line and word_idx[2:0] the pixel slot, matching the read-side address map.
REQ-023 The write SHALL appear the cycle after the DATA_LO byte is accepted: wea=1 for exactly one cycle, with addra/dina valid in that cycle.
REQ-024 addra and dina SHALL hold their last values while wea=0.
REQ-025 Every data byte SHALL be XOR-folded into the running checksum.
REQ-026 In CHECK, a byte equal to the checksum SHALL pulse done; any other value SHALL pulse error; either way the state returns to IDLE.
REQ-027 done/error SHALL pulse the cycle after the deciding byte and SHALL never be high together.
REQ-028 Words already written SHALL stay written on a checksum error (no rollback).
REQ-029 busy SHALL be 1 in CODE, DATA_HI, DATA_LO and CHECK, and 0 in IDLE.
REQ-030 A 16-bit idle counter SHALL clear on each accepted byte and increment each busy cycle with no byte.
REQ-031 When the idle counter reaches TIMEOUT, the block SHALL pulse error and return to IDLE; an already-scheduled wea SHALL still complete.
REQ-032 A byte arriving in the same cycle the counter would reach TIMEOUT SHALL be accepted and SHALL clear the counter, so no timeout occurs.
REQ-033 A 0x47 received outside IDLE SHALL be treated as ordinary data, with no resync.

Reset
REQ-034 When reset_n=0, the block SHALL go to IDLE immediately with wea=0, addra=0, dina=0, busy=0, done=0, error=0, checksums and counters at 0, and rx_ready=0.
REQ-035 rx_ready SHALL rise on the first clock after reset_n deasserts.
REQ-036 Reset in mid-frame SHALL abandon the frame with no done/error pulse; a pending write SHALL be dropped.

Verification
REQ-037 Good frame: 0x47, 0x41, words 0x0000..0x003F, checksum -> 64 wea pulses at addra 0x1040..0x107F with dina=0x0000..0x003F, then done=1 for one cycle.
REQ-038 Bad checksum: same frame with the checksum XOR 0x01 -> all 64 writes occur, then error pulses and done stays 0.
REQ-039 Invalid code: 0x47, 0x80 -> error pulse, zero wea, busy returns to 0.
REQ-040 Timeout with TIMEOUT=8: a 10-byte frame prefix, then a stall -> error pulses 8 cycles after the last byte, and the state is IDLE.
REQ-041 Noise: bytes 0x00, 0xFF, 0x41 in IDLE -> no busy, no wea; a following good frame loads normally.
REQ-042 Reset at word 20 -> outputs cleared asynchronously, no done/error pulse; the next frame starts from IDLE correctly.
